// File: rtl/mult_dot_acc.sv
// Dot-product accumulator behind the pipelined multiplier: sums every N valid
// products and presents each result on a valid/ready register with sticky drop flag.
module mult_dot_acc #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int AW = 2*W + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*W-1:0]  p_data,
    input  logic            p_valid,
    input  logic            clr,
    output logic [AW-1:0]   out_sum,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;

    logic          accept;
    logic          last;
    logic          complete;
    logic          take;
    logic [AW-1:0] p_ext;
    logic [AW-1:0] acc_base;
    logic [AW-1:0] sum;

    // NOTE: pure combinational decode uses assign; no always_comb here, so no latch risk.
    assign accept   = p_valid & ~clr;
    assign last     = (cnt == CW'(N - 1));
    assign complete = accept & last;
    assign take     = out_valid & out_ready;
    assign p_ext    = AW'(p_data);

    // The first product of a frame overwrites whatever acc held.
    assign acc_base = (cnt == '0) ? '0 : acc;
    assign sum      = acc_base + p_ext;

    assign busy = (cnt != '0);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
                acc <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                cnt <= last ? '0 : cnt + CW'(1);
                acc <= sum;
            end

            // complete implies !clr, so the ovf set below never races the clear above.
            if (complete) begin
                if (!out_valid || take) begin
                    out_sum   <= sum;
                    out_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mult_dot_acc.md
Name: mult_dot_acc

Overview:
- Downstream consumer of the pipelined multiplier (mult_LP_V1).
- Takes the multiplier's product stream, qualified by a valid bit that the integrator delays to match multiplier latency (W+1 cycles).
- Sums every N valid products into one dot-product result.
- Presents each result on a valid/ready output register with sticky overflow-drop detection; the multiplier pipeline cannot stall, so the input side has no backpressure.

Parameters:
- W, 8: multiplier operand width; product input is 2*W bits.
- N, 4: number of valid products summed per result; N >= 1.
- AW, 2*W+$clog2(N): accumulator/result width; sized so the sum can never overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- p_data  in  2*W  product from the multiplier's a_mult_b.
- p_valid  in  1  p_data is a valid product this cycle.
- clr  in  1  synchronous abort of the partial frame; also clears ovf.
- out_sum  out  AW  completed dot-product result.
- out_valid  out  1  out_sum holds an unconsumed result.
- out_ready  in  1  consumer accepts out_sum when out_valid is high.
- busy  out  1  partial frame in progress (cnt != 0).
- ovf  out  1  sticky: a completed result was dropped.

Behaviour:
- Reset (rst sampled high): acc=0, cnt=0, out_sum=0, out_valid=0, busy=0, ovf=0.
- rst has priority over all other inputs. A reset mid-frame discards the partial sum and any held result.
- Counter cnt runs 0..N-1 and advances only on cycles where p_valid=1 and clr=0. Idle cycles between products are allowed and do not affect the sum.
- Accumulation on an accepted product:
  - cnt==0: acc <= p_data, zero-extended to AW.
  - otherwise: acc <= acc + p_data.
- Completion occurs when an accepted product arrives with cnt==N-1:
  - sum = acc + p_data (for N=1, sum = p_data).
  - cnt <= 0; acc is don't-care.
- Result latency: out_valid rises the cycle after the completing p_valid is sampled.
- Output register rules, evaluated each cycle with take = out_valid & out_ready:
  - completion & (!out_valid | take): out_sum <= sum, out_valid <= 1. A completion and a handshake in the same cycle load back-to-back with no bubble and no ovf.
  - completion & out_valid & !out_ready: the new sum is dropped; out_sum is held unchanged; ovf <= 1.
  - no completion & take: out_valid <= 0; out_sum holds its last value.
- out_sum is stable while out_valid=1 and out_ready=0.
- clr=1:
  - cnt <= 0, acc <= 0, ovf <= 0.
  - Any p_valid in the same cycle is discarded.
  - out_sum/out_valid are unaffected, so a pending result survives clr.
  - clr never generates a completion.
- busy = (cnt != 0), driven combinationally from the register.
- Arithmetic is unsigned; no saturation is needed because AW covers N*(2^W-1)^2.

Test Plan (W=8, N=4, AW=18):
- Back-to-back frame: p_data 1,2,3,4 on 4 consecutive p_valid cycles, out_ready=1 -> out_valid=1 exactly 1 cycle after the 4th product, out_sum=10, busy=0, ovf=0.
- Max values with gaps: 4x p_data=65025 (255*255) with 1-3 idle cycles between each -> out_sum=260100, no wrap.
- Backpressure: out_ready=0; frames {1,1,1,1} then {2,2,2,2} -> out_sum=4 held, ovf=1 after 2nd completion. Then out_ready=1 for one cycle -> out_valid=0 next cycle. Then clr pulse -> ovf=0.
- Simultaneous handshake: result 10 pending, next frame {5,5,5,5} completes in the same cycle out_ready=1 -> out_valid stays 1, out_sum=20, ovf=0.
- clr mid-frame: products 7,7, then clr=1 with p_valid=1 and p_data=9, then 5,5,5,5 -> out_sum=20; busy=1 after the first 7, busy=0 after clr.
- Reset mid-operation: pending out_sum=10, 2 products into the next frame, rst pulse -> out_valid=0, out_sum=0, busy=0, ovf=0. The following frame {3,3,3,3} -> 12.
